// File: rtl/hazard_forward_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared definitions for the hazard/forwarding control slice.
//   - FSM state encoding of the hazard sequencer (RUN, STALL, FLUSH)
//   - Forward-select encoding, also used by the EX stage operand muxes
//   - fwdSelect: priority resolution of the two forwarding sources
// ----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    // Hazard sequencer states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Operand select encoding seen by the EX stage
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic logic [1:0] fwdSelect(input logic exmemHit, input logic memwbHit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (exmemHit) begin
            sel = FWD_EXMEM;
        end else if (memwbHit) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset, clears the count
//   inc   - count one event this cycle
//   clear - synchronous clear (takes priority over inc)
//   count - current count value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (inc && (countReg != {CNT_W{1'b1}})) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign count = countReg;

endmodule

// File: rtl/hazard_forward_unit.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit
// Control-side companion of the EX stage: generates forwarding selects from
// shadow copies of the EX/MEM and MEM/WB destinations, detects load-use
// hazards and sequences stalls / branch flushes of IF/ID and ID/EX.
// Ports:
//   clk, reset            - clock (rising edge), async active-low reset
//   id_rs/id_rt           - source fields of the instruction in IF/ID
//   id_use_rs/id_use_rt   - which of those sources are actually read
//   idex_rs/idex_rt       - sources of the instruction in EX
//   idex_memread          - instruction in EX is a load
//   idex_rt_dst           - load destination of the instruction in EX
//   ex_reg_address        - EX destination, already 0 when not writing
//   ex_memread            - instruction leaving EX is a load
//   ex_branch_taken       - branch decision from EX
//   forward_a/forward_b   - operand selects for EX
//   pc_write, ifid_write  - PC and IF/ID enables
//   ifid_flush            - load NOP into IF/ID
//   idex_bubble           - zero the ID/EX control word
//   stall_cnt, flush_cnt  - saturating event counters
// ----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt_dst,
    input  logic [REG_AW-1:0] ex_reg_address,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // ------------------------------------------------------------------
    // Shadow destination state. Updated every cycle regardless of stalls:
    // a stall bubbles EX, so the bubble's zero address flows through here.
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] exmemRdReg;
    logic              exmemLdReg;
    logic [REG_AW-1:0] memwbRdReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmemRdReg <= '0;
            exmemLdReg <= 1'b0;
            memwbRdReg <= '0;
        end else begin
            exmemRdReg <= ex_reg_address;
            exmemLdReg <= ex_memread;
            memwbRdReg <= exmemRdReg;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: one identical comparator pair per EX source operand.
    // Register 0 is hard-wired, so a zero destination never matches.
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] fwdSrc [2];
    logic [1:0]        fwdSel [2];

    assign fwdSrc[0] = idex_rs;
    assign fwdSrc[1] = idex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exmemHit;
            logic memwbHit;
            assign exmemHit   = (exmemRdReg != '0) && (exmemRdReg == fwdSrc[gi]);
            assign memwbHit   = (memwbRdReg != '0) && (memwbRdReg == fwdSrc[gi]);
            assign fwdSel[gi] = fwdSelect(exmemHit, memwbHit);
        end
    endgenerate

    assign forward_a = fwdSel[0];
    assign forward_b = fwdSel[1];

    // ------------------------------------------------------------------
    // Load-use detection against the instruction waiting in ID.
    // ------------------------------------------------------------------
    logic loadUse;

    assign loadUse = idex_memread && (idex_rt_dst != '0) &&
                     ((id_use_rs && (id_rs == idex_rt_dst)) ||
                      (id_use_rt && (id_rt == idex_rt_dst)));

    // ------------------------------------------------------------------
    // Hazard sequencer. FLUSH behaves exactly like RUN; it exists so the
    // state records that ID/EX currently carries a bubble. STALL refuses a
    // second consecutive stall because the load has already left EX.
    // A taken branch always wins over a stall request.
    // ------------------------------------------------------------------
    logic [1:0] stateReg;
    logic [1:0] stateNext;
    logic       stallIssue;
    logic       flushIssue;

    always_comb begin
        stateNext  = stateReg;
        stallIssue = 1'b0;
        flushIssue = 1'b0;
        // Gating on reset keeps every control idle while reset is held,
        // even though the inputs may still describe a hazard.
        if (reset) begin
            case (stateReg)
                ST_STALL: begin
                    if (ex_branch_taken) begin
                        flushIssue = 1'b1;
                        stateNext  = ST_FLUSH;
                    end else begin
                        stateNext  = ST_RUN;
                    end
                end
                default: begin
                    if (ex_branch_taken) begin
                        flushIssue = 1'b1;
                        stateNext  = ST_FLUSH;
                    end else if (loadUse) begin
                        stallIssue = 1'b1;
                        stateNext  = ST_STALL;
                    end else begin
                        stateNext  = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= ST_RUN;
        end else begin
            stateReg <= stateNext;
        end
    end

    assign pc_write    = !stallIssue;
    assign ifid_write  = !stallIssue;
    assign ifid_flush  = flushIssue;
    assign idex_bubble = flushIssue || stallIssue;

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallIssue),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushIssue),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int CW = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstN;
    logic [AW-1:0] idRs, idRt, idexRs, idexRt, idexRtDst, exRegAddress;
    logic          idUseRs, idUseRt, idexMemread, exMemread, exBranchTaken;
    logic [1:0]    forwardA, forwardB;
    logic          pcWrite, ifidWrite, ifidFlush, idexBubble;
    logic [CW-1:0] stallCnt, flushCnt;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .CNT_W  (CW),
        .REG_AW (AW)
    ) dut (
        .clk             (clk),
        .reset           (rstN),
        .id_rs           (idRs),
        .id_rt           (idRt),
        .id_use_rs       (idUseRs),
        .id_use_rt       (idUseRt),
        .idex_rs         (idexRs),
        .idex_rt         (idexRt),
        .idex_memread    (idexMemread),
        .idex_rt_dst     (idexRtDst),
        .ex_reg_address  (exRegAddress),
        .ex_memread      (exMemread),
        .ex_branch_taken (exBranchTaken),
        .forward_a       (forwardA),
        .forward_b       (forwardB),
        .pc_write        (pcWrite),
        .ifid_write      (ifidWrite),
        .ifid_flush      (ifidFlush),
        .idex_bubble     (idexBubble),
        .stall_cnt       (stallCnt),
        .flush_cnt       (flushCnt)
    );

    int errCount   = 0;
    int checkCount = 0;
    int cycleNum   = 0;

    // Reference model: destination history as a small array (index 0 is
    // the previous cycle, index 1 two cycles back), a "stalled last cycle"
    // flag and plain integer counters.
    int rdHist [2];
    bit prevStall;
    int mStallCnt, mFlushCnt;
    bit expStall, expFlush;
    localparam int CNT_MAX = (1 << CW) - 1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNum, obs, exp);
        end
    endtask

    task automatic modelReset();
        rdHist[0] = 0;
        rdHist[1] = 0;
        prevStall = 0;
        mStallCnt = 0;
        mFlushCnt = 0;
    endtask

    task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                         input int xrs, input int xrt, input bit mr, input int dst,
                         input int exa, input bit exmr, input bit br);
        idRs = rs[AW-1:0];  idRt = rt[AW-1:0];
        idUseRs = urs;      idUseRt = urt;
        idexRs = xrs[AW-1:0]; idexRt = xrt[AW-1:0];
        idexMemread = mr;   idexRtDst = dst[AW-1:0];
        exRegAddress = exa[AW-1:0];
        exMemread = exmr;   exBranchTaken = br;
        #1;
    endtask

    function automatic int expFwd(input int src);
        if (rdHist[0] != 0 && rdHist[0] == src) return 2;
        if (rdHist[1] != 0 && rdHist[1] == src) return 1;
        return 0;
    endfunction

    task automatic checkAll();
        bit lu;
        lu = idexMemread && idexRtDst != 0 &&
             ((idUseRs && idRs == idexRtDst) || (idUseRt && idRt == idexRtDst));
        expFlush = rstN && exBranchTaken;
        expStall = rstN && !exBranchTaken && lu && !prevStall;
        checkVal("forward_a",   forwardA,   expFwd(int'(idexRs)));
        checkVal("forward_b",   forwardB,   expFwd(int'(idexRt)));
        checkVal("pc_write",    pcWrite,    !expStall);
        checkVal("ifid_write",  ifidWrite,  !expStall);
        checkVal("ifid_flush",  ifidFlush,  expFlush);
        checkVal("idex_bubble", idexBubble, expStall || expFlush);
        checkVal("stall_cnt",   stallCnt,   mStallCnt);
        checkVal("flush_cnt",   flushCnt,   mFlushCnt);
    endtask

    task automatic stepClock();
        @(posedge clk);
        rdHist[1] = rdHist[0];
        rdHist[0] = int'(exRegAddress);
        prevStall = expStall;
        if (expStall && mStallCnt < CNT_MAX) mStallCnt++;
        if (expFlush && mFlushCnt < CNT_MAX) mFlushCnt++;
        $display("cycle %0d fa=%0d fb=%0d pcw=%0b flush=%0b bubble=%0b stalls=%0d flushes=%0d",
                 cycleNum, forwardA, forwardB, pcWrite, ifidFlush, idexBubble, stallCnt, flushCnt);
        cycleNum++;
        @(negedge clk);
    endtask

    initial begin
        rstN = 1'b0;
        modelReset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
        #1;

        // EX/MEM forward, then priority over MEM/WB with the same rd
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0); checkAll(); stepClock();
        drive(0, 0, 0, 0, 8, 0, 0, 0, 8, 0, 0); checkAll();
        checkVal("dir_exmem_fwd", forwardA, 2'b10); stepClock();
        drive(0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_exmem_prio", forwardA, 2'b10); stepClock();

        // MEM/WB forward and register 0
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0); checkAll(); stepClock();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkAll(); stepClock();
        drive(0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_memwb_fwd", forwardB, 2'b01);
        checkVal("dir_r0_nofwd", forwardA, 2'b00); stepClock();

        // Load-use stall, then idle, then MEM/WB forward of the load
        drive(5, 0, 1, 0, 0, 0, 1, 5, 5, 1, 0); checkAll();
        checkVal("dir_lu_pcw", pcWrite, 1'b0);
        checkVal("dir_lu_bubble", idexBubble, 1'b1); stepClock();
        drive(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_lu_idle", pcWrite, 1'b1);
        checkVal("dir_lu_cnt", stallCnt, 1); stepClock();
        drive(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_lu_fwd", forwardA, 2'b01); stepClock();

        // Branch flush for exactly one cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkAll();
        checkVal("dir_br_flush", ifidFlush, 1'b1);
        checkVal("dir_br_pcw", pcWrite, 1'b1); stepClock();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_br_once", ifidFlush, 1'b0);
        checkVal("dir_br_cnt", flushCnt, 1); stepClock();

        // Branch and load-use together: flush wins
        drive(3, 0, 1, 0, 0, 0, 1, 3, 0, 1, 1); checkAll();
        checkVal("dir_both_pcw", pcWrite, 1'b1);
        checkVal("dir_both_flush", ifidFlush, 1'b1); stepClock();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkAll();
        checkVal("dir_both_stallcnt", stallCnt, 1); stepClock();

        // Saturation: five separate stalls
        for (int i = 0; i < 5; i++) begin
            drive(7, 7, 0, 1, 0, 0, 1, 7, 0, 1, 0); checkAll(); stepClock();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkAll(); stepClock();
        end
        checkVal("dir_sat", stallCnt, 3);

        // Asynchronous reset in the middle of a stall
        drive(6, 0, 1, 0, 0, 0, 1, 6, 6, 1, 0); checkAll();
        checkVal("dir_rst_pre", pcWrite, 1'b0);
        rstN = 1'b0;
        #1;
        checkVal("dir_rst_pcw", pcWrite, 1'b1);
        checkVal("dir_rst_bubble", idexBubble, 1'b0);
        checkVal("dir_rst_stallcnt", stallCnt, 0);
        checkVal("dir_rst_flushcnt", flushCnt, 0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        #1;

        // Randomized traffic with dense register collisions
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  ($urandom_range(0, 4) == 0));
            checkAll();
            stepClock();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
